hazard_exc_ctrl: RTL

Pipeline sequencing controller for the five-stage MIPS core. It generates the stage-register enable, flush and exception-request signals (F_en, D_en, E_flush, Req) from decoded hazard information. It also owns the multiply/divide busy timer that governs HI/LO access. Every pipeline register (D_REG through W_REG) and the MDU are driven from this block.

---
 rtl/hazard_exc_ctrl_pkg.sv | 30 +++
 rtl/hazard_exc_ctrl_md_busy_timer.sv | 46 ++++
 rtl/hazard_exc_ctrl.sv | 78 +++++++
 3 files changed

// File: rtl/hazard_exc_ctrl_pkg.sv
// Shared constants and helpers for the pipeline hazard/exception controller.
package hazard_exc_ctrl_pkg;

  // Default MDU latencies, counted in cycles after the start in E.
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Tuse/Tnew encodings; T_NONE marks an operand or result that is not used.
  localparam logic [1:0] T_0    = 2'd0;
  localparam logic [1:0] T_1    = 2'd1;
  localparam logic [1:0] T_2    = 2'd2;
  localparam logic [1:0] T_NONE = 2'd3;

  // Exception vector loaded into the M-stage PC by the stage registers on Req.
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

  // A producer in a later stage: its destination and remaining latency.
  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] tnew;
  } prod_t;

  // A source needs the producer's value before it will be ready.
  function automatic logic reg_hazard(input logic [4:0] src,
                                      input logic [1:0] tuse,
                                      input prod_t      p);
    return (p.dst == src) && (p.dst != 5'd0) && (tuse < p.tnew);
  endfunction

endpackage

// File: rtl/hazard_exc_ctrl_md_busy_timer.sv
// Multiply/divide busy timer: counts down the MDU latency after a start in E.
module md_busy_timer
  import hazard_exc_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic div_i,
  input  logic req_i,
  output logic busy_o
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: a start squashed by Req does not load; otherwise count down to 0.
  always_comb begin
    count_d = count_q;
    if (start_i && !req_i) begin
      count_d = div_i ? DIV_LOAD : MULT_LOAD;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register; reset dominates any start in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign busy_o = (count_q != '0);

endmodule

// File: rtl/hazard_exc_ctrl.sv
// Pipeline sequencing controller: stall/flush/exception-request generation.
module hazard_exc_ctrl
  import hazard_exc_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_tuse_rs,
  input  logic [1:0] D_tuse_rt,
  input  logic [4:0] E_dst,
  input  logic [4:0] M_dst,
  input  logic [1:0] E_tnew,
  input  logic [1:0] M_tnew,
  input  logic       D_is_md,
  input  logic       E_md_start,
  input  logic       E_md_div,
  input  logic       D_eret,
  input  logic       E_mtc0_epc,
  input  logic       M_mtc0_epc,
  input  logic       M_exc,
  output logic       F_en,
  output logic       D_en,
  output logic       E_flush,
  output logic       Req,
  output logic       md_busy
);

  prod_t      prod [2];
  logic [1:0] reg_hz;
  logic       md_hz;
  logic       epc_hz;
  logic       stall;
  logic       req_int;

  assign prod[0] = '{dst: E_dst, tnew: E_tnew};
  assign prod[1] = '{dst: M_dst, tnew: M_tnew};

  // One comparator pair (rs, rt) per producing stage: E then M.
  for (genvar gi = 0; gi < 2; gi++) begin : g_stage
    assign reg_hz[gi] = reg_hazard(D_rs, D_tuse_rs, prod[gi]) |
                        reg_hazard(D_rt, D_tuse_rt, prod[gi]);
  end

  assign md_hz   = D_is_md && (md_busy || E_md_start);
  assign epc_hz  = D_eret && (E_mtc0_epc || M_mtc0_epc);
  assign stall   = (|reg_hz) || md_hz || epc_hz;
  assign req_int = M_exc && !reset;

  md_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_timer (
    .clk     (clk),
    .reset   (reset),
    .start_i (E_md_start),
    .div_i   (E_md_div),
    .req_i   (req_int),
    .busy_o  (md_busy)
  );

  // Stage controls: reset and Req let everything run (registers self-clear), else stall.
  always_comb begin
    F_en    = 1'b1;
    D_en    = 1'b1;
    E_flush = 1'b0;
    Req     = req_int;
    if (!reset && !req_int && stall) begin
      F_en    = 1'b0;
      D_en    = 1'b0;
      E_flush = 1'b1;
    end
  end

endmodule
